// File: rtl/spi_bus_arbiter.sv
// Registered request/grant arbiter that shares one SPI pad set between the memory and peripheral engines.
// Optional build macro SPI_ARB_STARVE_GUARD_EN: after MAX_MEM_BURST contested memory grants, the peripheral wins.
module spi_bus_arbiter #(
  parameter int unsigned TURNAROUND    = 2,
  parameter int unsigned MAX_MEM_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_req,
  output logic       mem_gnt,
  input  logic       per_req,
  output logic       per_gnt,
  input  logic       mem_sclk,
  input  logic       mem_mosi,
  input  logic       mem_cs_ram_n,
  input  logic       mem_cs_flash_n,
  input  logic       per_sclk,
  input  logic       per_mosi,
  input  logic [5:0] per_cs_n,
  output logic       bus_sclk,
  output logic       bus_mosi,
  output logic       bus_cs_ram_n,
  output logic       bus_cs_flash_n,
  output logic [5:0] bus_cs_per_n,
  output logic [1:0] owner
);

  // state | meaning
  // IDLE  | bus free, no owner, arbitrate every cycle
  // MEM   | memory engine owns the bus until mem_req drops
  // PER   | peripheral engine owns the bus until per_req drops
  // TURN  | forced idle gap; arbitrate on the edge where turn_cnt is 1
  typedef enum logic [1:0] {S_IDLE, S_MEM, S_PER, S_TURN} state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND);

  if (TURNAROUND < 1 || TURNAROUND > 15 || MAX_MEM_BURST < 1 || MAX_MEM_BURST > 15) begin : g_param_check
    $error("spi_bus_arbiter: TURNAROUND and MAX_MEM_BURST must be within 1..15");
  end

  state_t     state, state_nxt, arb_state;
  logic [3:0] turn_cnt, turn_cnt_nxt;
  logic       mem_wins;

`ifdef SPI_ARB_STARVE_GUARD_EN
  localparam logic [3:0] BURST_MAX = 4'(MAX_MEM_BURST);
  logic [3:0] burst_cnt;

  assign mem_wins = mem_req && !(per_req && (burst_cnt == BURST_MAX));

  // Counts fresh memory grants taken while the peripheral was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= 4'd0;
    end else if (state_nxt == S_PER && state != S_PER) begin
      burst_cnt <= 4'd0;
    end else if (state_nxt == S_MEM && state != S_MEM && per_req) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end
`else
  assign mem_wins = mem_req;
`endif

  always_comb begin
    arb_state = S_IDLE;
    if (mem_wins) begin
      arb_state = S_MEM;
    end else if (per_req) begin
      arb_state = S_PER;
    end
  end

  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    case (state)
      S_IDLE: state_nxt = arb_state;
      S_MEM: begin
        if (!mem_req) begin
          state_nxt    = S_TURN;
          turn_cnt_nxt = TURN_LOAD;
        end
      end
      S_PER: begin
        if (!per_req) begin
          state_nxt    = S_TURN;
          turn_cnt_nxt = TURN_LOAD;
        end
      end
      S_TURN: begin
        turn_cnt_nxt = turn_cnt - 4'd1;
        if (turn_cnt == 4'd1) begin
          state_nxt = arb_state;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      turn_cnt <= 4'd0;
      mem_gnt  <= 1'b0;
      per_gnt  <= 1'b0;
      owner    <= 2'b00;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
      mem_gnt  <= (state_nxt == S_MEM);
      per_gnt  <= (state_nxt == S_PER);
      owner    <= {state_nxt == S_PER, state_nxt == S_MEM};
    end
  end

  // Pad mux follows the registered owner so reset idles the bus without waiting for a clock.
  always_comb begin
    bus_sclk       = 1'b0;
    bus_mosi       = 1'b0;
    bus_cs_ram_n   = 1'b1;
    bus_cs_flash_n = 1'b1;
    bus_cs_per_n   = 6'b111111;
    case (owner)
      2'b01: begin
        bus_sclk       = mem_sclk;
        bus_mosi       = mem_mosi;
        bus_cs_ram_n   = mem_cs_ram_n;
        bus_cs_flash_n = mem_cs_flash_n;
      end
      2'b10: begin
        bus_sclk     = per_sclk;
        bus_mosi     = per_mosi;
        bus_cs_per_n = per_cs_n;
      end
      default: ;
    endcase
  end

endmodule
